my_pc16: RTL and testbench

MY_PC16 -- requirements
Module: my_pc16

---
 rtl/my_pc16.sv | 155 +++++++++++++++
 tb/tb_my_pc16.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/my_pc16.sv
// my_pc16: 16-bit program counter with clear/load/inc and an optional
// LIFO return stack (call/ret), enabled by macro MY_PC16_RET_STACK_EN.
// Ports: clk, rst_n (async, active low), in[15:0] target, clr, load,
//   inc, call, ret controls; out[15:0] registered PC; stack_empty,
//   stack_full (decoded from count), stack_err (sticky over/underflow).
// One action per edge, priority clr > load > ret > call > inc > hold.
module my_pc16 #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        clr,
  input  logic        load,
  input  logic        inc,
  input  logic        call,
  input  logic        ret,
  output logic [15:0] out,
  output logic        stack_empty,
  output logic        stack_full,
  output logic        stack_err
);

  typedef enum logic [2:0] {
    A_HOLD,
    A_CLR,
    A_LOAD,
    A_RET,
    A_CALL,
    A_INC
  } act_t;

  act_t        act;
  logic [15:0] out_inc;
  logic [15:0] out_nxt;

  assign out_inc = out + 16'd1;

`ifdef MY_PC16_RET_STACK_EN

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          err_nxt;
  logic          push;
  logic          empty;
  logic          full;
  logic [AW-1:0] top;
  logic [15:0]   stk [DEPTH];

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign top   = AW'(cnt - 1'b1);

  always_comb begin
    if (clr)       act = A_CLR;
    else if (load) act = A_LOAD;
    else if (ret)  act = A_RET;
    else if (call) act = A_CALL;
    else if (inc)  act = A_INC;
    else           act = A_HOLD;
  end

  always_comb begin
    out_nxt = out;
    cnt_nxt = cnt;
    err_nxt = stack_err;
    push    = 1'b0;
    unique case (act)
      A_CLR: begin
        out_nxt = 16'h0000;
        cnt_nxt = '0;
        err_nxt = 1'b0;
      end
      A_LOAD: out_nxt = in;
      A_RET: begin
        if (empty) begin
          err_nxt = 1'b1;
        end else begin
          out_nxt = stk[top];
          cnt_nxt = cnt - 1'b1;
        end
      end
      A_CALL: begin
        out_nxt = in;
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          push    = 1'b1;
          cnt_nxt = cnt + 1'b1;
        end
      end
      A_INC:  out_nxt = out_inc;
      A_HOLD: out_nxt = out;
      default: out_nxt = out;
    endcase
  end

  // Entries are only ever read below the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) stk[cnt[AW-1:0]] <= out_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 16'h0000;
      cnt       <= '0;
      stack_err <= 1'b0;
    end else begin
      out       <= out_nxt;
      cnt       <= cnt_nxt;
      stack_err <= err_nxt;
    end
  end

  assign stack_empty = empty;
  assign stack_full  = full;

`else

  logic unused_ret;
  assign unused_ret = ret;

  // Without a stack, call degenerates to a plain jump.
  always_comb begin
    if (clr)              act = A_CLR;
    else if (load | call) act = A_LOAD;
    else if (inc)         act = A_INC;
    else                  act = A_HOLD;
  end

  always_comb begin
    out_nxt = out;
    unique case (act)
      A_CLR:   out_nxt = 16'h0000;
      A_LOAD:  out_nxt = in;
      A_INC:   out_nxt = out_inc;
      A_HOLD:  out_nxt = out;
      default: out_nxt = out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 16'h0000;
    else        out <= out_nxt;
  end

  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;

`endif

endmodule

// File: tb/tb_my_pc16.sv
// tb_my_pc16: table-driven self-checking bench for my_pc16
// with a scoreboard queue of expected post-edge results.
module tb_my_pc16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = '0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] out;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_err;

  my_pc16 #(.DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .clr(clr),
    .load(load),
    .inc(inc),
    .call(call),
    .ret(ret),
    .out(out),
    .stack_empty(stack_empty),
    .stack_full(stack_full),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        clr;
    logic        load;
    logic        inc;
    logic        call;
    logic        ret;
    logic [15:0] in;
    logic [15:0] eo;
    logic        ee;
    logic        ef;
    logic        er;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(string nm, logic c, logic l, logic i,
                              logic ca, logic r, logic [15:0] d,
                              logic [15:0] eo, logic ee, logic ef,
                              logic er);
    vec_t v;
    v.nm = nm; v.clr = c; v.load = l; v.inc = i; v.call = ca;
    v.ret = r; v.in = d; v.eo = eo; v.ee = ee; v.ef = ef; v.er = er;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_now(vec_t e);
    chk({e.nm, ".out"}, out, e.eo);
    chk({e.nm, ".empty"}, 16'(stack_empty), 16'(e.ee));
    chk({e.nm, ".full"}, 16'(stack_full), 16'(e.ef));
    chk({e.nm, ".err"}, 16'(stack_err), 16'(e.er));
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    clr = v.clr; load = v.load; inc = v.inc;
    call = v.call; ret = v.ret; in = v.in;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      check_now(e);
    end
  endtask

  initial begin
    vec_t r;
    // name, clr, load, inc, call, ret, in, out, empty, full, err
    add("ld10",     0, 1, 0, 0, 0, 16'h0010, 16'h0010, 1, 0, 0);
    add("prio_clr", 1, 1, 1, 0, 0, 16'h5555, 16'h0000, 1, 0, 0);
    add("prio_ld",  0, 1, 1, 0, 0, 16'h5555, 16'h5555, 1, 0, 0);
    add("inc",      0, 0, 1, 0, 0, 16'h0000, 16'h5556, 1, 0, 0);
    add("hold",     0, 0, 0, 0, 0, 16'hAAAA, 16'h5556, 1, 0, 0);
    add("ldffff",   0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 0);
    add("wrap",     0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
`ifdef MY_PC16_RET_STACK_EN
    add("ld100",    0, 1, 0, 0, 0, 16'h0100, 16'h0100, 1, 0, 0);
    add("call1",    0, 0, 0, 1, 0, 16'h2000, 16'h2000, 0, 0, 0);
    add("ret1",     0, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0, 0);
    add("ldA00",    0, 1, 0, 0, 0, 16'h0A00, 16'h0A00, 1, 0, 0);
    add("ov_c1",    0, 0, 0, 1, 0, 16'h1000, 16'h1000, 0, 0, 0);
    add("ov_c2",    0, 0, 0, 1, 0, 16'h2000, 16'h2000, 0, 0, 0);
    add("ov_c3",    0, 0, 0, 1, 0, 16'h3000, 16'h3000, 0, 0, 0);
    add("ov_c4",    0, 0, 0, 1, 0, 16'h4000, 16'h4000, 0, 1, 0);
    add("ov_c5",    0, 0, 0, 1, 0, 16'h5000, 16'h5000, 0, 1, 1);
    add("ov_r1",    0, 0, 0, 0, 1, 16'h0000, 16'h3001, 0, 0, 1);
    add("ov_r2",    0, 0, 0, 0, 1, 16'h0000, 16'h2001, 0, 0, 1);
    add("ov_r3",    0, 0, 0, 0, 1, 16'h0000, 16'h1001, 0, 0, 1);
    add("ov_r4",    0, 0, 0, 0, 1, 16'h0000, 16'h0A01, 1, 0, 1);
    add("ov_r5",    0, 0, 0, 0, 1, 16'h0000, 16'h0A01, 1, 0, 1);
    add("clr_err",  1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add("cr_ld",    0, 1, 0, 0, 0, 16'h0300, 16'h0300, 1, 0, 0);
    add("cr_push",  0, 0, 0, 1, 0, 16'h0400, 16'h0400, 0, 0, 0);
    add("cr_both",  0, 0, 0, 1, 1, 16'h0700, 16'h0301, 1, 0, 0);
    add("uf_ret",   0, 0, 1, 1, 1, 16'h0700, 16'h0301, 1, 0, 1);
    add("ret_ld",   0, 1, 0, 0, 1, 16'h0800, 16'h0800, 1, 0, 1);
`else
    add("call42",   0, 0, 0, 1, 0, 16'h0042, 16'h0042, 1, 0, 0);
    add("retinc",   0, 0, 1, 0, 1, 16'h0000, 16'h0043, 1, 0, 0);
    add("ret_hold", 0, 0, 0, 0, 1, 16'h0000, 16'h0043, 1, 0, 0);
    add("call_ld",  0, 1, 0, 1, 0, 16'h1111, 16'h1111, 1, 0, 0);
    add("call_ret", 0, 0, 0, 1, 1, 16'h7000, 16'h7000, 1, 0, 0);
    add("clr",      1, 0, 0, 1, 1, 16'h7777, 16'h0000, 1, 0, 0);
`endif
    add("ld1234",   0, 1, 0, 0, 0, 16'h1234, 16'h1234, 1, 0, 0);

    #12;
    r.nm = "reset"; r.eo = 16'h0000; r.ee = 1; r.ef = 0; r.er = 0;
    check_now(r);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset in mid-cycle, checked before the next edge.
    #3;
    rst_n = 1'b0;
    #1;
    r.nm = "async_rst"; r.eo = 16'h0000; r.ee = 1; r.ef = 0; r.er = 0;
    check_now(r);
    clr = 0; load = 0; inc = 0; call = 0; ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    r.nm = "post_rst_inc"; r.clr = 0; r.load = 0; r.inc = 1;
    r.call = 0; r.ret = 0; r.in = 16'h0000;
    r.eo = 16'h0001; r.ee = 1; r.ef = 0; r.er = 0;
    apply(r);

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
